router_term_in_fifo: RTL
========================

# router_term_in_fifo

Per-terminal ingress buffer feeding one router input terminal. It accepts packets from the terminal-side driver, rejects packets with an invalid destination, and queues the rest in a DEPTH-entry FIFO. The queue head is presented to the router on `data_out_i_in`/`pndng_i_in`, and the router consumes it with `popin`. One instance sits upstream of each of the 2*ROWS+2*COLUMS router terminals.

## Interface
- `PCK_SZ`, 40: packet width in bits.
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `N_TERMS`, 16: number of router terminals; valid destinations are 0..N_TERMS-1.
- `TERM_ID`, 0: index of the terminal this instance feeds.
- `DST_MSB`, 39 / `DST_LSB`, 34: bounds of the 6-bit destination field in the packet.
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `push`  in  1  driver offers `data_in` this cycle.
- `data_in`  in  PCK_SZ  packet offered by the driver.
- `full`  out  1  high when count == DEPTH.
- `data_out_i_in`  out  PCK_SZ  FIFO head to router; zero when empty.
- `pndng_i_in`  out  1  high when count > 0.
- `popin`  in  1  router consumes the head.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `drop_cnt`  out  16  packets rejected (invalid destination or overflow); saturates at 16'hFFFF.
- `overflow`  out  1  sticky; set on a push that was refused because the FIFO was full.
- `underflow`  out  1  sticky; set on `popin` while empty.
- `clr_stats`  in  1  synchronous clear of `drop_cnt`, `overflow` and `underflow`.

## Operation
- Destination check: with dst = data_in[DST_MSB:DST_LSB], a packet is valid iff dst < N_TERMS and dst != TERM_ID.
- Push accepted iff push && valid && (count < DEPTH || pop_eff).
- pop_eff = popin && count > 0.
- Storage: circular buffer with rd/wr pointers of $clog2(DEPTH) bits each; pointers wrap from DEPTH-1 to 0.
- Count update (next cycle):
  - push accepted only: +1.
  - pop_eff only: -1.
  - Both: unchanged; head advances and the new entry is written at wr.
- push && !valid: packet is discarded and `drop_cnt` is incremented. Occupancy is never affected.
- push && valid && full && !popin: packet is discarded, `drop_cnt` is incremented and `overflow` is set.
- popin while empty: no state change except `underflow` set. Any push in the same cycle is processed normally.
- `clr_stats`:
  - Clears the stats in that cycle and has priority over increments in the same cycle.
  - FIFO contents and pointers are unaffected.
- `drop_cnt` is incremented by at most 1 per cycle.
- Output decode:
  - `data_out_i_in` = mem[rd] when count > 0, else 0.
  - `pndng_i_in` = (count > 0) and `full` = (count == DEPTH), both decoded from registered count.
- Packet contents pass through unmodified; storage order equals acceptance order.

## Timing
- Reset, asynchronous and immediate: pointers and count = 0, `drop_cnt` = 0, `overflow` = `underflow` = 0.
  - Resulting outputs: `pndng_i_in` = 0, `full` = 0, `data_out_i_in` = 0.
  - Memory array is not reset and is never observable while empty.
- Reset mid-operation: all queued packets are lost; the first push after deassertion behaves as into an empty FIFO.
- Push-to-visible latency: a push accepted into an empty FIFO at edge k gives `pndng_i_in` = 1 with that packet on `data_out_i_in` after edge k.
- Pop: `popin` sampled at edge k with `pndng_i_in` high removes the head. The next entry, or 0/`pndng_i_in` low, is visible after edge k.
  - Back-to-back `popin` every cycle drains one entry per cycle.
- Router contract: `pndng_i_in` stays high and `data_out_i_in` stays stable until `popin`. The block never withdraws a pending packet.
- Push and pop at full: accepted with zero bubble; `full` stays high.
- Push and popin at empty: pop ignored (`underflow` set), push accepted; count = 1 next cycle.
- Throughput: one accepted push and one pop per cycle, sustained.

## Test plan
- Reset, then push 3 valid packets (dst = 1, 2, 3; TERM_ID = 0), then popin for 3 cycles.
  - `pndng_i_in` rises 1 cycle after the first push and count peaks at 3.
  - Heads appear in order 1, 2, 3; then `pndng_i_in` = 0 and `data_out_i_in` = 0.
- Fill with 16 pushes and no pops; `full` = 1. Push a 17th packet.
  - Packet is rejected, `overflow` = 1, `drop_cnt` = 1, count stays 16.
  - Head is still the first packet.
- At full, assert push and popin together for 20 cycles.
  - count stays 16, no drops.
  - Output order equals input order across the pointer wrap.
- Push dst = 0 (self), then dst = 16 (out of range), then dst = 5.
  - `drop_cnt` = 2, count = 1, head dst = 5.
- popin on an empty FIFO together with a push of dst = 7.
  - `underflow` = 1, count = 1.
  - Assert `clr_stats`: `underflow` and `drop_cnt` clear, packet still pending.
- Queue 4 packets, assert `reset` mid-cycle.
  - Outputs go to 0 without waiting for a clock edge.
  - After deassertion, a single push is visible 1 cycle later with count = 1.

Source files
------------

// File: rtl/router_term_in_fifo.sv
// Ingress buffer for one router input terminal: filters packets by destination,
// queues accepted ones in a circular FIFO and presents the head to the router.
module router_term_in_fifo #(
  parameter int unsigned PCK_SZ  = 40,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned N_TERMS = 16,
  parameter int unsigned TERM_ID = 0,
  parameter int unsigned DST_MSB = 39,
  parameter int unsigned DST_LSB = 34
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [PCK_SZ-1:0]          data_in,
  output logic                       full,
  output logic [PCK_SZ-1:0]          data_out_i_in,
  output logic                       pndng_i_in,
  input  logic                       popin,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                drop_cnt,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_stats
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [PCK_SZ-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [15:0]       drop_q, drop_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  logic [31:0] dst_ext;
  logic        dst_ok, pop_eff, push_ok, drop, ovf_set;

  assign dst_ext = 32'(data_in[DST_MSB:DST_LSB]);
  assign dst_ok  = (dst_ext < N_TERMS) && (dst_ext != TERM_ID);

  assign pndng_i_in = (count_q != '0);
  assign full       = (count_q == CW'(DEPTH));

  // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
  assign pop_eff = popin && pndng_i_in;
  assign push_ok = push && dst_ok && (!full || pop_eff);
  assign ovf_set = push && dst_ok && full && !pop_eff;
  assign drop    = push && (!dst_ok || ovf_set);

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    if (push_ok) wr_d = wr_q + AW'(1);
    if (pop_eff) rd_d = rd_q + AW'(1);

    unique case ({push_ok, pop_eff})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (clr_stats) begin
      drop_d = '0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
    end else begin
      if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      if (ovf_set)                    ovf_d  = 1'b1;
      if (popin && !pndng_i_in)       unf_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is left unreset; it is only read through the count-gated head mux.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= data_in;
  end

  assign data_out_i_in = pndng_i_in ? mem[rd_q] : '0;
  assign count         = count_q;
  assign drop_cnt      = drop_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;

endmodule
